sram_bus_arbiter: RTL and testbench

//  Shares the two off-chip SRAMs (base_ram, ext_ram) between the instruction-fetch port (IF) and the data port (MEM).

---
 rtl/sram_bus_pkg.sv | 19 +
 rtl/sram_channel.sv | 93 +++++++++
 rtl/sram_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_sram_bus_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_pkg.sv
// Shared constants and types for the SRAM bus arbiter and its per-SRAM channels.
// UART register addresses, channel FSM states, port ownership and the latched request record.
package sram_bus_pkg;

  localparam logic [31:0] UART_DATA = 32'hbfd003f8;
  localparam logic [31:0] UART_STAT = 32'hbfd003fc;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} chan_state_t;
  typedef enum logic {INST, DATA} owner_t;

  typedef struct packed {
    logic [19:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    owner_t      owner;
  } chan_req_t;

endpackage

// File: rtl/sram_channel.sv
// One SRAM access engine: latches a granted request, drives WAIT_CYCLES of strobes, then a 1-cycle DONE.
// Latency WAIT_CYCLES+2 cycles per access; a new grant is only taken in IDLE, so requesters wait for ready.
module sram_channel
  import sram_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        grant_i,
  input  chan_req_t   req_i,
  input  logic [31:0] ram_rdata_i,
  output logic        idle_o,
  output logic        done_o,
  output owner_t      owner_o,
  output logic [31:0] rdata_o,
  output logic [19:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic        ram_oe_o,
  output logic        ram_ce_n_o,
  output logic        ram_oe_n_o,
  output logic        ram_we_n_o,
  output logic [3:0]  ram_be_n_o
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  chan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  chan_req_t     req_q, req_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          access, last_cyc, wr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d = ACCESS;
          cnt_d   = CW'(WAIT_CYCLES - 1);
          req_d   = req_i;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!req_q.we) rdata_d = ram_rdata_i;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign access   = (state_q == ACCESS);
  assign last_cyc = (cnt_q == '0);
  assign wr       = access & req_q.we;

  // we_n releases one cycle early so data and address stay valid past the write edge.
  assign ram_ce_n_o  = ~access;
  assign ram_oe_n_o  = ~(access & ~req_q.we);
  assign ram_we_n_o  = ~(wr & ~last_cyc);
  assign ram_oe_o    = wr;
  // Reads enable all byte lanes; writes use the requested lanes.
  assign ram_be_n_o  = !access ? 4'hf : (req_q.we ? ~req_q.be : 4'h0);
  assign ram_addr_o  = req_q.waddr;
  assign ram_wdata_o = req_q.wdata;

  assign idle_o  = (state_q == IDLE);
  assign done_o  = (state_q == DONE);
  assign owner_o = req_q.owner;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares base_ram/ext_ram between IF and MEM ports, routes UART addresses, returns one-cycle ready pulses.
// SRAM latency WAIT_CYCLES+2 per access; UART completes on uart_ack; ungranted ports see ready=0 and must hold.
module sram_bus_arbiter
  import sram_bus_pkg::chan_req_t, sram_bus_pkg::owner_t, sram_bus_pkg::INST, sram_bus_pkg::DATA;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] UART_DATA   = sram_bus_pkg::UART_DATA,
  parameter logic [31:0] UART_STAT   = sram_bus_pkg::UART_STAT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ready,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ready,
  output logic        uart_req,
  output logic        uart_we,
  output logic        uart_sel,
  output logic [31:0] uart_wdata,
  input  logic [31:0] uart_rdata,
  input  logic        uart_ack,
  output logic [19:0] base_ram_addr,
  output logic [31:0] base_ram_wdata,
  input  logic [31:0] base_ram_rdata,
  output logic        base_ram_oe,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n,
  output logic [3:0]  base_ram_be_n,
  output logic [19:0] ext_ram_addr,
  output logic [31:0] ext_ram_wdata,
  input  logic [31:0] ext_ram_rdata,
  output logic        ext_ram_oe,
  output logic        ext_ram_ce_n,
  output logic        ext_ram_oe_n,
  output logic        ext_ram_we_n,
  output logic [3:0]  ext_ram_be_n
);

  logic        uart_hit, data_sram, done_q, uart_done;
  logic [1:0]  inst_tgt, data_tgt, grant, gdata, idle, done, inst_hit, data_hit;
  owner_t      lg_q [2];
  owner_t      lg_d [2];
  owner_t      owner [2];
  chan_req_t   creq [2];
  logic [31:0] rdata [2];
  logic        unused_inst_bits;

  assign uart_hit  = (data_addr == UART_DATA) || (data_addr == UART_STAT);
  assign data_sram = data_req & ~uart_hit;
  // Bit 0 = base_ram, bit 1 = ext_ram.
  assign inst_tgt  = {inst_req & inst_addr[22], inst_req & ~inst_addr[22]};
  assign data_tgt  = {data_sram & data_addr[22], data_sram & ~data_addr[22]};
  assign unused_inst_bits = ^{inst_addr[31:23], inst_addr[1:0]};

  // On contention the port that did not win last time goes first.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      grant[c] = 1'b0;
      gdata[c] = 1'b0;
      lg_d[c]  = lg_q[c];
      if (idle[c] && (inst_tgt[c] || data_tgt[c])) begin
        grant[c] = 1'b1;
        gdata[c] = data_tgt[c] && (!inst_tgt[c] || lg_q[c] == INST);
        lg_d[c]  = gdata[c] ? DATA : INST;
      end
      creq[c] = gdata[c] ? '{waddr: data_addr[21:2], wdata: data_wdata, be: data_be, we: data_we, owner: DATA}
                         : '{waddr: inst_addr[21:2], wdata: 32'h0, be: 4'hf, we: 1'b0, owner: INST};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lg_q[0] <= INST;
      lg_q[1] <= INST;
      done_q  <= 1'b0;
    end else begin
      lg_q[0] <= lg_d[0];
      lg_q[1] <= lg_d[1];
      done_q  <= uart_done;
    end
  end

  sram_channel #(.WAIT_CYCLES(WAIT_CYCLES)) u_base (
    .clk(clk), .resetn(resetn), .grant_i(grant[0]), .req_i(creq[0]), .ram_rdata_i(base_ram_rdata),
    .idle_o(idle[0]), .done_o(done[0]), .owner_o(owner[0]), .rdata_o(rdata[0]),
    .ram_addr_o(base_ram_addr), .ram_wdata_o(base_ram_wdata), .ram_oe_o(base_ram_oe),
    .ram_ce_n_o(base_ram_ce_n), .ram_oe_n_o(base_ram_oe_n), .ram_we_n_o(base_ram_we_n),
    .ram_be_n_o(base_ram_be_n)
  );

  sram_channel #(.WAIT_CYCLES(WAIT_CYCLES)) u_ext (
    .clk(clk), .resetn(resetn), .grant_i(grant[1]), .req_i(creq[1]), .ram_rdata_i(ext_ram_rdata),
    .idle_o(idle[1]), .done_o(done[1]), .owner_o(owner[1]), .rdata_o(rdata[1]),
    .ram_addr_o(ext_ram_addr), .ram_wdata_o(ext_ram_wdata), .ram_oe_o(ext_ram_oe),
    .ram_ce_n_o(ext_ram_ce_n), .ram_oe_n_o(ext_ram_oe_n), .ram_we_n_o(ext_ram_we_n),
    .ram_be_n_o(ext_ram_be_n)
  );

  // done_q suppresses a second UART access while MEM still holds the request after its ready.
  assign uart_req   = data_req & uart_hit & ~done_q;
  assign uart_we    = data_we;
  assign uart_sel   = (data_addr == UART_STAT);
  assign uart_wdata = data_wdata;
  assign uart_done  = uart_req & uart_ack;

  assign inst_hit   = {done[1] && owner[1] == INST, done[0] && owner[0] == INST};
  assign data_hit   = {done[1] && owner[1] == DATA, done[0] && owner[0] == DATA};
  assign inst_ready = |inst_hit;
  assign inst_rdata = inst_hit[0] ? rdata[0] : (inst_hit[1] ? rdata[1] : 32'h0);
  assign data_ready = (|data_hit) | uart_done;
  assign data_rdata = uart_done ? uart_rdata :
                      (data_hit[0] ? rdata[0] : (data_hit[1] ? rdata[1] : 32'h0));

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: SRAM/UART models, directed table, corner sequences, random pairs vs a cycle model.
module tb_sram_bus_arbiter;

  localparam int W    = 2;
  localparam int NCYC = 14;
  localparam logic [31:0] UD = 32'hbfd003f8;
  localparam logic [31:0] US = 32'hbfd003fc;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req, data_we, uart_req, uart_we, uart_sel, uart_ack;
  logic        inst_ready, data_ready;
  logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata, uart_wdata, uart_rdata;
  logic [3:0]  data_be;
  logic [19:0] base_ram_addr, ext_ram_addr;
  logic [31:0] base_ram_wdata, base_ram_rdata, ext_ram_wdata, ext_ram_rdata;
  logic        base_ram_oe, base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
  logic        ext_ram_oe, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
  logic [3:0]  base_ram_be_n, ext_ram_be_n;

  sram_bus_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ready(data_ready),
    .uart_req(uart_req), .uart_we(uart_we), .uart_sel(uart_sel), .uart_wdata(uart_wdata),
    .uart_rdata(uart_rdata), .uart_ack(uart_ack),
    .base_ram_addr(base_ram_addr), .base_ram_wdata(base_ram_wdata), .base_ram_rdata(base_ram_rdata),
    .base_ram_oe(base_ram_oe), .base_ram_ce_n(base_ram_ce_n), .base_ram_oe_n(base_ram_oe_n),
    .base_ram_we_n(base_ram_we_n), .base_ram_be_n(base_ram_be_n),
    .ext_ram_addr(ext_ram_addr), .ext_ram_wdata(ext_ram_wdata), .ext_ram_rdata(ext_ram_rdata),
    .ext_ram_oe(ext_ram_oe), .ext_ram_ce_n(ext_ram_ce_n), .ext_ram_oe_n(ext_ram_oe_n),
    .ext_ram_we_n(ext_ram_we_n), .ext_ram_be_n(ext_ram_be_n)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int ch, input int i);
    return 32'h2402_0001 ^ (32'(i) * 32'h9e37_79b1) ^ (32'(ch) << 28);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // SRAM models: data only drives when selected for read, writes need we_n, ce_n and the data driver.
  logic [31:0] bmem [256];
  logic [31:0] emem [256];
  logic        mem_init;
  logic [7:0]  init_idx;

  always @(posedge clk) begin
    if (mem_init) begin
      bmem[init_idx] <= init_word(0, int'(init_idx));
      emem[init_idx] <= init_word(1, int'(init_idx));
    end else begin
      if (!base_ram_ce_n && !base_ram_we_n && base_ram_oe)
        bmem[base_ram_addr[7:0]] <= merge(bmem[base_ram_addr[7:0]], base_ram_wdata, ~base_ram_be_n);
      if (!ext_ram_ce_n && !ext_ram_we_n && ext_ram_oe)
        emem[ext_ram_addr[7:0]] <= merge(emem[ext_ram_addr[7:0]], ext_ram_wdata, ~ext_ram_be_n);
    end
  end

  assign base_ram_rdata = (!base_ram_ce_n && !base_ram_oe_n) ? bmem[base_ram_addr[7:0]] : 32'hdead_beef;
  assign ext_ram_rdata  = (!ext_ram_ce_n && !ext_ram_oe_n) ? emem[ext_ram_addr[7:0]] : 32'hdead_beef;

  int n_tests, n_fail;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    bit          tab;
    logic        ie;
    logic [31:0] ia;
    logic        de;
    logic        dw;
    logic [3:0]  dbe;
    logic [31:0] da;
    logic [31:0] dwd;
    int          lat;
    logic [31:0] uval;
    int          eic;
    int          edc;
  } vec_t;

  // Reference state: memory contents and last winner per SRAM (0 = IF, 1 = MEM).
  logic [31:0] shadow [2][256];
  int          lg [2];

  // Both requests start in cycle 0; the grant edge ends cycle 0, so a lone SRAM access is ready at W+1.
  task automatic model_pair(input vec_t v, output int eic, output logic [31:0] eird,
                            output int edc, output logic [31:0] edrd);
    int   ich, dch;
    logic dfirst;
    ich  = int'(v.ia[22]);
    dch  = (v.da == UD || v.da == US) ? 2 : int'(v.da[22]);
    eic  = -1; edc = -1; eird = '0; edrd = '0;
    dfirst = 1'b1;
    if (v.ie && v.de && ich == dch) begin
      dfirst = (lg[ich] == 0);
      if (dfirst) begin edc = W + 1; eic = 2 * W + 3; lg[ich] = 0; end
      else        begin eic = W + 1; edc = 2 * W + 3; lg[ich] = 1; end
    end else begin
      if (v.ie) begin eic = W + 1; lg[ich] = 0; end
      if (v.de) begin
        if (dch == 2) edc = v.lat;
        else begin edc = W + 1; lg[dch] = 1; end
      end
    end
    if (v.ie && !dfirst) eird = shadow[ich][v.ia[9:2]];
    if (v.de) begin
      if (dch == 2) edrd = v.uval;
      else if (v.dw) shadow[dch][v.da[9:2]] = merge(shadow[dch][v.da[9:2]], v.dwd, v.dbe);
      else edrd = shadow[dch][v.da[9:2]];
    end
    if (v.ie && dfirst) eird = shadow[ich][v.ia[9:2]];
  endtask

  logic [NCYC-1:0] h_bce, h_boe, h_bwe, h_ece, h_ewe, h_eoe;
  logic [3:0]      h_ebe [NCYC];

  // Drives one IF/MEM request pair for NCYC cycles, dropping each request the cycle after its ready.
  task automatic run_pair(input vec_t v, output int ic, output int in_, output logic [31:0] ird,
                          output int dc, output int dn, output logic [31:0] drd);
    ic = -1; dc = -1; in_ = 0; dn = 0; ird = '0; drd = '0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      inst_req   = v.ie && (in_ == 0);
      inst_addr  = v.ia;
      data_req   = v.de && (dn == 0);
      data_we    = v.dw;
      data_be    = v.dbe;
      data_addr  = v.da;
      data_wdata = v.dwd;
      uart_rdata = v.uval;
      uart_ack   = v.de && (dn == 0) && (c >= v.lat);
      #1;
      h_bce[c] = base_ram_ce_n; h_boe[c] = base_ram_oe_n; h_bwe[c] = base_ram_we_n;
      h_ece[c] = ext_ram_ce_n;  h_ewe[c] = ext_ram_we_n;  h_eoe[c] = ext_ram_oe;
      h_ebe[c] = ext_ram_be_n;
      if (inst_ready === 1'b1) begin
        in_++;
        if (ic < 0) begin ic = c; ird = inst_rdata; end
      end
      if (data_ready === 1'b1) begin
        dn++;
        if (dc < 0) begin dc = c; drd = data_rdata; end
      end
    end
    inst_req = 1'b0; data_req = 1'b0; uart_ack = 1'b0;
  endtask

  task automatic exec(input vec_t v, input string tag);
    int          ic, in_, dc, dn, meic, medc;
    logic [31:0] ird, drd, mird, mdrd;
    model_pair(v, meic, mird, medc, mdrd);
    run_pair(v, ic, in_, ird, dc, dn, drd);
    check({tag, " inst_ready_cycle"}, 64'(ic), 64'(v.tab ? v.eic : meic));
    check({tag, " data_ready_cycle"}, 64'(dc), 64'(v.tab ? v.edc : medc));
    check({tag, " inst_ready_count"}, 64'(in_), 64'(v.ie ? 1 : 0));
    check({tag, " data_ready_count"}, 64'(dn), 64'(v.de ? 1 : 0));
    if (v.ie) check({tag, " inst_rdata"}, 64'(ird), 64'(mird));
    if (v.de && !v.dw) check({tag, " data_rdata"}, 64'(drd), 64'(mdrd));
  endtask

  vec_t        vt [11];
  vec_t        v;
  int          ic, in_, dc, dn, rcnt, rd_cyc;
  logic [31:0] ird, drd;

  initial begin
    n_tests = 0; n_fail = 0;
    resetn = 1'b0; mem_init = 1'b1; init_idx = '0;
    inst_req = 0; inst_addr = '0; data_req = 0; data_we = 0; data_be = '0; data_addr = '0;
    data_wdata = '0; uart_rdata = '0; uart_ack = 0;
    lg[0] = 0; lg[1] = 0;

    //        tab ie  ia            de dw dbe    da            dwd           lat uval          eic edc
    vt[0]  = '{1, 1, 32'h80000000, 0, 0, 4'h0, 32'h00000000, 32'h0,        0, 32'h0,        3, -1};
    vt[1]  = '{1, 1, 32'h80000010, 1, 0, 4'h0, 32'h80000100, 32'h0,        0, 32'h0,        7,  3};
    vt[2]  = '{1, 1, 32'h80000000, 1, 1, 4'h3, 32'h80400004, 32'hcafe1234, 0, 32'h0,        3,  3};
    vt[3]  = '{1, 0, 32'h00000000, 1, 1, 4'hf, UD,           32'h00000041, 3, 32'h0,       -1,  3};
    vt[4]  = '{1, 0, 32'h00000000, 1, 0, 4'h0, US,           32'h0,        1, 32'h00000021, -1, 1};
    vt[5]  = '{1, 1, 32'h80400000, 1, 0, 4'h0, 32'h80400008, 32'h0,        0, 32'h0,        3,  7};
    vt[6]  = '{1, 0, 32'h00000000, 1, 0, 4'h0, 32'h80400004, 32'h0,        0, 32'h0,       -1,  3};
    vt[7]  = '{1, 1, 32'h80000008, 1, 0, 4'h0, US,           32'h0,        0, 32'h5a5a0001, 3,  0};
    vt[8]  = '{1, 1, 32'h80000040, 1, 1, 4'hf, 32'h80000040, 32'h11223344, 0, 32'h0,        7,  3};
    vt[9]  = '{1, 0, 32'h00000000, 1, 1, 4'h8, 32'h80400010, 32'h99aabbcc, 0, 32'h0,       -1,  3};
    vt[10] = '{1, 1, 32'h80400010, 0, 0, 4'h0, 32'h00000000, 32'h0,        0, 32'h0,        3, -1};

    for (int i = 0; i < 256; i++) begin
      shadow[0][i] = init_word(0, i);
      shadow[1][i] = init_word(1, i);
    end
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      init_idx = 8'(i);
    end
    @(negedge clk);
    mem_init = 1'b0;

    #1;
    check("reset strobes", 64'({base_ram_ce_n, base_ram_oe_n, base_ram_we_n, base_ram_be_n,
                                ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n, ext_ram_be_n}), 64'h3fff);
    check("reset ram_oe", 64'({base_ram_oe, ext_ram_oe}), 64'h0);
    check("reset ready", 64'({inst_ready, data_ready, uart_req}), 64'h0);
    check("reset rdata", 64'({inst_rdata, data_rdata}), 64'h0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 11; i++) exec(vt[i], $sformatf("vec%0d", i));

    // Single read strobe shape: ce_n/oe_n low in cycles 1..2 only.
    v = vt[0];
    exec(v, "single");
    check("single base_ce_n", 64'(h_bce[5:0]), 64'b111001);
    check("single base_oe_n", 64'(h_boe[5:0]), 64'b111001);
    check("single base_we_n", 64'(h_bwe[5:0]), 64'b111111);

    // Parallel IF read on base with a partial write on ext.
    v = vt[2];
    v.dwd = 32'h0bad_f00d;
    exec(v, "parallel");
    check("parallel base_ce_n", 64'(h_bce[5:0]), 64'b111001);
    check("parallel ext_ce_n", 64'(h_ece[5:0]), 64'b111001);
    check("parallel ext_we_n", 64'(h_ewe[5:0]), 64'b111101);
    check("parallel ext_ram_oe", 64'(h_eoe[5:0]), 64'b000110);
    check("parallel ext_be_n c1", 64'(h_ebe[1]), 64'b1100);
    check("parallel ext_be_n c2", 64'(h_ebe[2]), 64'b1100);

    // UART write held one cycle past its ack with ack still high.
    rcnt = 0; rd_cyc = -1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      data_req = 1'b1; data_we = 1'b1; data_addr = UD; data_wdata = 32'h41; data_be = 4'hf;
      uart_ack = (c >= 3);
      #1;
      if (c == 0) check("uart write fields", 64'({uart_req, uart_sel, uart_we, uart_wdata}), 64'h5_0000_0041);
      if (c == 4) check("uart_req after ack", 64'(uart_req), 64'h0);
      if (data_ready === 1'b1) begin
        rcnt++;
        if (rd_cyc < 0) rd_cyc = c;
      end
    end
    data_req = 1'b0; uart_ack = 1'b0;
    check("uart ready cycle", 64'(rd_cyc), 64'd3);
    check("uart ready count", 64'(rcnt), 64'd1);

    // Reset in the first ACCESS cycle aborts the access at once.
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h80000000; data_req = 1'b0;
    @(negedge clk);
    #1;
    check("pre-reset base_ce_n", 64'(base_ram_ce_n), 64'h0);
    resetn = 1'b0;
    #1;
    check("async reset strobes", 64'({base_ram_ce_n, base_ram_oe_n}), 64'h3);
    inst_req = 1'b0;
    rcnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (inst_ready === 1'b1) rcnt++;
    end
    check("no ready after abort", 64'(rcnt), 64'h0);
    @(negedge clk);
    resetn = 1'b1;
    lg[0] = 0; lg[1] = 0;
    exec(vt[0], "post-reset");

    for (int k = 0; k < 40; k++) begin
      v.tab  = 1'b0;
      v.ie   = 1'($urandom_range(0, 1));
      v.ia   = 32'h8000_0000 | (32'($urandom_range(0, 1)) << 22) | (32'($urandom_range(0, 7)) << 2);
      v.de   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) v.da = $urandom_range(0, 1) ? UD : US;
      else v.da = 32'h8000_0000 | (32'($urandom_range(0, 1)) << 22) | (32'($urandom_range(0, 7)) << 2);
      v.dw   = 1'($urandom_range(0, 1));
      v.dbe  = 4'($urandom_range(0, 15));
      v.dwd  = $urandom;
      v.lat  = int'($urandom_range(0, 4));
      v.uval = $urandom;
      v.eic  = 0;
      v.edc  = 0;
      if (!v.ie && !v.de) v.ie = 1'b1;
      exec(v, $sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
